pipelined_adder: RTL and testbench



---
 rtl/pipelined_adder_if.sv | 44 ++++
 rtl/pipelined_adder.sv | 149 ++++++++++++++
 tb/tb_pipelined_adder.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder_if
// Description : Operand/result handshake bundle for pipelined_adder.
//               Upstream side : in_valid, in_ready, a, b, cin (+ sub when
//               PIPELINED_ADDER_SUB_EN is defined).
//               Downstream    : out_valid, out_ready, sum, cout, ovf.
//               master = producer/consumer side, slave = the adder.
// Revision    : 1.0  initial release
// ============================================================================
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef PIPELINED_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
`ifdef PIPELINED_ADDER_SUB_EN
        , output sub
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
`ifdef PIPELINED_ADDER_SUB_EN
        , input sub
`endif
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder
// Description : WIDTH-bit adder whose carry chain is cut into STAGES
//               registered segments of SEG = WIDTH/STAGES bits. One result
//               per clock; latency STAGES cycles. Reports carry-out and
//               signed overflow.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - pipelined_adder_if.slave (valid/ready in and out,
//                      a, b, cin, sum, cout, ovf)
// Options     : PIPELINED_ADDER_SUB_EN - adds bus.sub; sub=1 computes
//               a + ~b + cin (a - b when cin=1).
// Revision    : 1.0  initial release
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pipelined_adder_if.slave   bus
);
    localparam int SEG = WIDTH / STAGES;

    logic             stall;
    logic             advance;
    logic [WIDTH-1:0] b_eff;

    // Single global stall: the whole pipe freezes only when a finished
    // result is waiting on the consumer.
    assign stall        = bus.out_valid & ~bus.out_ready;
    assign advance      = ~stall;
    assign bus.in_ready = advance;

    // Subtraction is folded into the operand before it enters the pipe,
    // so every stage is a plain adder.
    always_comb begin
`ifdef PIPELINED_ADDER_SUB_EN
        b_eff = bus.b ^ {WIDTH{bus.sub}};
`else
        b_eff = bus.b;
`endif
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO   = k * SEG;     // first operand bit added here
        localparam int DONE = LO + SEG;    // sum bits known after this stage

        // Operand bits LO and up, right-aligned (skew path into this stage).
        logic [WIDTH-LO-1:0] a_in;
        logic [WIDTH-LO-1:0] b_in;
        logic                valid_in;
        logic                carry_in;
        logic [SEG:0]        seg_total;
        logic [DONE-1:0]     sum_d;
        logic [DONE-1:0]     sum_q;
        logic                valid_d;
        logic                valid_q;
        logic                carry_d;
        logic                carry_q;

        if (k == 0) begin : g_first
            always_comb begin
                a_in     = bus.a;
                b_in     = b_eff;
                valid_in = bus.in_valid;
                carry_in = bus.cin;
                sum_d    = seg_total[SEG-1:0];
            end
        end else begin : g_later
            always_comb begin
                a_in     = g_stage[k-1].g_fwd.a_q;
                b_in     = g_stage[k-1].g_fwd.b_q;
                valid_in = g_stage[k-1].valid_q;
                carry_in = g_stage[k-1].carry_q;
                // New segment on top of the deskewed lower sum bits.
                sum_d    = {seg_total[SEG-1:0], g_stage[k-1].sum_q};
            end
        end

        always_comb begin
            seg_total = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]}
                      + {{SEG{1'b0}}, carry_in};
            valid_d   = valid_in;
            carry_d   = seg_total[SEG];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (advance) begin
                valid_q <= valid_d;
                carry_q <= carry_d;
                sum_q   <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Operand bits not yet consumed ride along to later stages.
            logic [WIDTH-DONE-1:0] a_d;
            logic [WIDTH-DONE-1:0] a_q;
            logic [WIDTH-DONE-1:0] b_d;
            logic [WIDTH-DONE-1:0] b_q;

            always_comb begin
                a_d = a_in[WIDTH-LO-1:SEG];
                b_d = b_in[WIDTH-LO-1:SEG];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : g_last
            logic msb_carry;
            logic ovf_d;
            logic ovf_q;

            // Carry into the MSB recovered from the MSB's own sum equation.
            always_comb begin
                msb_carry = a_in[SEG-1] ^ b_in[SEG-1] ^ seg_total[SEG-1];
                ovf_d     = msb_carry ^ seg_total[SEG];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].valid_q;
    assign bus.sum       = g_stage[STAGES-1].sum_q;
    assign bus.cout      = g_stage[STAGES-1].carry_q;
    assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_adder
// Description : Scoreboard bench for pipelined_adder (WIDTH=16). Main DUT
//               has STAGES=2; two extra instances (STAGES=1, STAGES=4)
//               confirm latency. Honours PIPELINED_ADDER_SUB_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_adder;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(WIDTH)) bus  ();
    pipelined_adder_if #(.WIDTH(WIDTH)) bus1 ();
    pipelined_adder_if #(.WIDTH(WIDTH)) bus4 ();

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
    pipelined_adder #(.WIDTH(WIDTH), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    pipelined_adder #(.WIDTH(WIDTH), .STAGES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    res_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Downstream ready: either bench-controlled or randomised each cycle.
    logic rdy_manual;
    logic rdy_rand = 1'b1;
    logic rdy_mode = 1'b0;
    always @(posedge clk) rdy_rand <= ($urandom_range(0, 3) != 0);
    assign bus.out_ready  = rdy_mode ? rdy_rand : rdy_manual;
    assign bus1.out_ready = 1'b1;
    assign bus4.out_ready = 1'b1;

    // Reference: integer arithmetic plus sign rule for overflow.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        res_t             r;
        logic [WIDTH-1:0] bv;
        int unsigned      total;
        bv     = sub ? ~b : b;
        total  = 32'(a) + 32'(bv) + 32'(cin);
        r.sum  = total[WIDTH-1:0];
        r.cout = (total >= (32'd1 << WIDTH));
        r.ovf  = (a[WIDTH-1] == bv[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Present one beat (called at posedge+1); holds until accepted.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub);
        bit accepted;
        int guard;
        accepted     = 1'b0;
        guard        = 0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
`ifdef PIPELINED_ADDER_SUB_EN
        bus.sub      = sub;
`endif
        do begin
            @(negedge clk);
            accepted = bus.in_ready;
            if (accepted) exp_q.push_back(model(a, b, cin, sub));
            @(posedge clk);
            #1;
            guard++;
        end while (!accepted && guard < 200);
        if (!accepted) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: actual=not accepted required=accepted within 200 cycles");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_outstanding", exp_q.size(), 0);
    endtask

    // Monitor: compare every presented result with the queue head; pop on transfer.
    always @(negedge clk) begin : monitor
        res_t e;
        if (!rst) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: actual out_valid=1 sum=0x%0h required no result", bus.sum);
                end else begin
                    e = exp_q[0];
                    check("sum",  bus.sum,  e.sum);
                    check("cout", bus.cout, e.cout);
                    check("ovf",  bus.ovf,  e.ovf);
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            check("in_ready_rule", bus.in_ready, !(bus.out_valid && !bus.out_ready));
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        res_t e;
        int   lat;
        logic [WIDTH-1:0] ra, rb;
        logic             rs;

        rst          = 1'b1;
        rdy_manual   = 1'b0;
        bus.in_valid = 1'b0;  bus.a  = '0; bus.b  = '0; bus.cin  = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
`ifdef PIPELINED_ADDER_SUB_EN
        bus.sub = 1'b0; bus1.sub = 1'b0; bus4.sub = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_sum",       bus.sum,       0);
        check("reset_cout",      bus.cout,      0);
        check("reset_ovf",       bus.ovf,       0);
        check("reset_in_ready",  bus.in_ready,  1);
        rst        = 1'b0;
        rdy_manual = 1'b1;
        @(posedge clk);
        #1;

        // Latency 2 on the main instance.
        send(16'hFF00, 16'hFFFF, 1'b1, 1'b0);
        check("latency_early_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        check("latency_valid", bus.out_valid, 1);
        wait_drain();

        // Overflow corner cases.
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0);
        wait_drain();

        // Back-to-back beats, including the wrap case.
        send(16'h0000, 16'h0000, 1'b1, 1'b0);
        send(16'h0001, 16'h0001, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        send(16'h1234, 16'h4321, 1'b0, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        wait_drain();

        // Backpressure: stall three cycles with a result waiting.
        send(16'h1111, 16'h2222, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0002, 1'b0, 1'b0);
        send(16'h4000, 16'h4000, 1'b1, 1'b0);
        rdy_manual = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready",  bus.in_ready,  0);
            @(posedge clk);
            #1;
        end
        rdy_manual = 1'b1;
        wait_drain();

        // Asynchronous reset with beats in flight.
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        send(16'h8000, 16'hFFFF, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", bus.out_valid, 0);
        check("async_rst_sum",       bus.sum,       0);
        check("async_rst_cout",      bus.cout,      0);
        check("async_rst_ovf",       bus.ovf,       0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            check("post_rst_no_stale", bus.out_valid, 0);
        end

`ifdef PIPELINED_ADDER_SUB_EN
        send(16'h0005, 16'h0007, 1'b1, 1'b1);
        send(16'h8000, 16'h0001, 1'b1, 1'b1);
        send(16'h0007, 16'h0005, 1'b1, 1'b1);
        wait_drain();
`endif

        // Randomised traffic with random gaps and random downstream ready.
        rdy_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                ra = WIDTH'($urandom);
                rb = WIDTH'($urandom);
                if ($urandom_range(0, 7) == 0) ra = '1;
                if ($urandom_range(0, 7) == 0) rb = '1;
`ifdef PIPELINED_ADDER_SUB_EN
                rs = 1'($urandom_range(0, 1));
`else
                rs = 1'b0;
`endif
                send(ra, rb, 1'($urandom_range(0, 1)), rs);
            end
        end
        rdy_mode = 1'b0;
        wait_drain();

        // Latency of the STAGES=1 and STAGES=4 instances.
        bus1.in_valid = 1'b1; bus1.a = 16'h1234; bus1.b = 16'h4321; bus1.cin = 1'b1;
        bus4.in_valid = 1'b1; bus4.a = 16'h1234; bus4.b = 16'h4321; bus4.cin = 1'b1;
        e = model(16'h1234, 16'h4321, 1'b1, 1'b0);
`ifdef PIPELINED_ADDER_SUB_EN
        bus1.a = 16'h0005; bus1.b = 16'h0007; bus1.sub = 1'b1;
        bus4.a = 16'h0005; bus4.b = 16'h0007; bus4.sub = 1'b1;
        e = model(16'h0005, 16'h0007, 1'b1, 1'b1);
`endif
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        bus4.in_valid = 1'b0;
        lat = 1;
        check("s1_latency_valid", bus1.out_valid, 1);
        check("s1_sum",  bus1.sum,  e.sum);
        check("s1_cout", bus1.cout, e.cout);
        while (!bus4.out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("s4_latency", lat, 4);
        check("s4_sum",  bus4.sum,  e.sum);
        check("s4_cout", bus4.cout, e.cout);
        check("s4_ovf",  bus4.ovf,  e.ovf);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
